// File: rtl/prod_accum_pkg.sv
// Shared types and default constants for the prod_accum block accumulator.
package prod_accum_pkg;

    localparam int unsigned DEF_P_W   = 16;
    localparam int unsigned DEF_ACC_W = 20;
    localparam int unsigned LEN_MAX   = 255;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/prod_accum_acc_add_sat.sv
// Combinational accumulator adder: zero-extends the product, reports carry out.
// PROD_ACCUM_SAT_EN selects saturate-on-overflow; otherwise the result wraps.
module acc_add_sat
    import prod_accum_pkg::*;
#(
    parameter int unsigned P_W   = DEF_P_W,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [P_W-1:0]   prod,
    output logic [ACC_W-1:0] sum_c,
    output logic             ovf_c
);

    localparam int unsigned FULL_W = ACC_W + 1;

    logic [FULL_W-1:0] full;

    always_comb begin
        full  = FULL_W'(acc) + FULL_W'(prod);
        ovf_c = full[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        sum_c = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        sum_c = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accum.sv
// Sums LEN unsigned products per block, then holds the block sum until taken.
// Overflow behaviour (wrap or saturate) is set by PROD_ACCUM_SAT_EN.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned P_W   = DEF_P_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prod_valid,
    input  logic [P_W-1:0]   prod,
    output logic             prod_ready,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'((LEN > LEN_MAX) ? LEN_MAX : LEN);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             sum_valid_q, sum_valid_d;
    logic             prod_ready_q, prod_ready_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;

    acc_add_sat #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc   (acc_q),
        .prod  (prod),
        .sum_c (add_sum),
        .ovf_c (add_ovf)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        ovf_d        = ovf_q;
        sum_valid_d  = sum_valid_q;
        prod_ready_d = prod_ready_q;
        cnt_inc      = cnt_q + CNT_W'(1);

        case (state_q)
            ST_ACC: begin
                if (prod_valid && prod_ready_q) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_ovf;
                    // Final accept of the block: capture result and stop accepting.
                    if (cnt_inc == LEN_C) begin
                        state_d      = ST_HOLD;
                        sum_d        = add_sum;
                        sum_valid_d  = 1'b1;
                        prod_ready_d = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (sum_valid_q && sum_ready) begin
                    state_d      = ST_ACC;
                    acc_d        = '0;
                    cnt_d        = '0;
                    ovf_d        = 1'b0;
                    sum_valid_d  = 1'b0;
                    prod_ready_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_ACC;
                sum_valid_d  = 1'b0;
                prod_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            ovf_q        <= 1'b0;
            sum_valid_q  <= 1'b0;
            prod_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            ovf_q        <= ovf_d;
            sum_valid_q  <= sum_valid_d;
            prod_ready_q <= prod_ready_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign sum_valid  = sum_valid_q;
    assign sum        = sum_q;
    assign cnt        = cnt_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: LEN=4, LEN=32 and LEN=1 instances, scoreboarded sums.
module tb_prod_accum;
    import prod_accum_pkg::*;

    localparam int unsigned PW = 16;
    localparam int unsigned AW = 20;

    typedef struct packed {
        logic [AW-1:0] sum;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_pv, a_pr, a_sv, a_sr, a_ovf;
    logic [PW-1:0] a_p;
    logic [AW-1:0] a_sum;
    logic [7:0]    a_cnt;

    logic          b_pv, b_pr, b_sv, b_sr, b_ovf;
    logic [PW-1:0] b_p;
    logic [AW-1:0] b_sum;
    logic [7:0]    b_cnt;

    logic          c_pv, c_pr, c_sv, c_sr, c_ovf;
    logic [PW-1:0] c_p;
    logic [AW-1:0] c_sum;
    logic [7:0]    c_cnt;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_cmp = 0;
    int n_err = 0;

    prod_accum #(.P_W(PW), .ACC_W(AW), .LEN(4)) u_dut_a (
        .clk(clk), .rst(rst), .prod_valid(a_pv), .prod(a_p), .prod_ready(a_pr),
        .sum_valid(a_sv), .sum_ready(a_sr), .sum(a_sum), .cnt(a_cnt), .ovf(a_ovf)
    );

    prod_accum #(.P_W(PW), .ACC_W(AW), .LEN(32)) u_dut_b (
        .clk(clk), .rst(rst), .prod_valid(b_pv), .prod(b_p), .prod_ready(b_pr),
        .sum_valid(b_sv), .sum_ready(b_sr), .sum(b_sum), .cnt(b_cnt), .ovf(b_ovf)
    );

    prod_accum #(.P_W(PW), .ACC_W(AW), .LEN(1)) u_dut_c (
        .clk(clk), .rst(rst), .prod_valid(c_pv), .prod(c_p), .prod_ready(c_pr),
        .sum_valid(c_sv), .sum_ready(c_sr), .sum(c_sum), .cnt(c_cnt), .ovf(c_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for sum_valid on the chosen instance, then score it.
    task automatic check_sum(input string tag, input int which);
        exp_t          e;
        logic          sv;
        logic [AW-1:0] s;
        logic          o;
        logic          got;
        logic          have;
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            sv = (which == 0) ? a_sv : (which == 1) ? b_sv : c_sv;
            if (sv) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            have = 1'b0;
            e    = '0;
            case (which)
                0: if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
                1: if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
                default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
            endcase
            chk({tag, "_sb_entry"}, 32'(have), 32'd1);
            s = (which == 0) ? a_sum : (which == 1) ? b_sum : c_sum;
            o = (which == 0) ? a_ovf : (which == 1) ? b_ovf : c_ovf;
            if (have) begin
                chk({tag, "_sum"}, 32'(s), 32'(e.sum));
                chk({tag, "_ovf"}, 32'(o), 32'(e.ovf));
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        a_pv = 1'b0; a_p = '0; a_sr = 1'b0;
        b_pv = 1'b0; b_p = '0; b_sr = 1'b0;
        c_pv = 1'b0; c_p = '0; c_sr = 1'b1;
        step();
        step();

        chk("rst_cnt",   32'(a_cnt), 32'd0);
        chk("rst_sv",    32'(a_sv),  32'd0);
        chk("rst_pr",    32'(a_pr),  32'd1);
        chk("rst_sum",   32'(a_sum), 32'd0);
        chk("rst_ovf",   32'(a_ovf), 32'd0);
        rst = 1'b1;

        // Four back-to-back beats of 64.
        for (int i = 0; i < 4; i++) begin
            a_pv = 1'b1;
            a_p  = 16'd64;
            if (i == 3) q_a.push_back({20'd256, 1'b0});
            step();
            chk("b2b_cnt", 32'(a_cnt), 32'(i + 1));
            chk("b2b_sv_latency", 32'(a_sv), (i == 3) ? 32'd1 : 32'd0);
        end
        a_pv = 1'b0;
        check_sum("b2b", 0);
        a_sr = 1'b1;
        step();
        a_sr = 1'b0;
        chk("b2b_clear_sv",  32'(a_sv),  32'd0);
        chk("b2b_clear_cnt", 32'(a_cnt), 32'd0);
        chk("b2b_clear_pr",  32'(a_pr),  32'd1);

        // Gapped beats: cnt moves only on accepts.
        for (int i = 0; i < 4; i++) begin
            a_pv = 1'b1;
            a_p  = 16'd64;
            if (i == 3) q_a.push_back({20'd256, 1'b0});
            step();
            chk("gap_cnt_accept", 32'(a_cnt), 32'(i + 1));
            a_pv = 1'b0;
            a_p  = 16'd5;
            step();
            chk("gap_cnt_bubble", 32'(a_cnt), 32'(i + 1));
        end
        check_sum("gap", 0);

        // Hold with back-pressure while products are offered.
        a_pv = 1'b1;
        a_p  = 16'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pr",  32'(a_pr),  32'd0);
            chk("hold_sum", 32'(a_sum), 32'd256);
            chk("hold_cnt", 32'(a_cnt), 32'd4);
            chk("hold_sv",  32'(a_sv),  32'd1);
        end
        a_sr = 1'b1;
        step();
        a_sr = 1'b0;
        chk("hold_release_cnt", 32'(a_cnt), 32'd0);
        chk("hold_release_pr",  32'(a_pr),  32'd1);
        chk("hold_release_sv",  32'(a_sv),  32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q_a.push_back({20'd20, 1'b0});
            step();
            chk("next_cnt", 32'(a_cnt), 32'(i + 1));
        end
        a_pv = 1'b0;
        check_sum("next", 0);
        a_sr = 1'b1;
        step();
        a_sr = 1'b0;

        // Reset in the middle of a block.
        a_pv = 1'b1;
        a_p  = 16'd64;
        step();
        step();
        a_pv = 1'b0;
        chk("mid_cnt_pre", 32'(a_cnt), 32'd2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_cnt", 32'(a_cnt), 32'd0);
        chk("mid_rst_sv",  32'(a_sv),  32'd0);
        chk("mid_rst_pr",  32'(a_pr),  32'd1);
        a_pv = 1'b1;
        a_p  = 16'd1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q_a.push_back({20'd4, 1'b0});
            step();
        end
        a_pv = 1'b0;
        check_sum("post_rst", 0);
        a_sr = 1'b1;
        step();
        a_sr = 1'b0;

        // LEN=32 of 0xFFFF: overflows a 20-bit accumulator.
        b_pv = 1'b1;
        b_p  = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
`ifdef PROD_ACCUM_SAT_EN
            if (i == 31) q_b.push_back({20'hFFFFF, 1'b1});
`else
            if (i == 31) q_b.push_back({20'hFFFE0, 1'b1});
`endif
            step();
        end
        b_pv = 1'b0;
        chk("len32_cnt", 32'(b_cnt), 32'd32);
        check_sum("len32", 1);
        b_sr = 1'b1;
        step();
        b_sr = 1'b0;
        chk("len32_clear_ovf", 32'(b_ovf), 32'd0);

        // LEN=1 with sum_ready tied high: a result every other cycle.
        c_pv = 1'b1;
        c_p  = 16'd3;
        q_c.push_back({20'd3, 1'b0});
        step();
        chk("len1_sv_first", 32'(c_sv), 32'd1);
        check_sum("len1_a", 2);
        c_p = 16'd7;
        step();
        chk("len1_sv_gap", 32'(c_sv), 32'd0);
        chk("len1_pr_gap", 32'(c_pr), 32'd1);
        q_c.push_back({20'd7, 1'b0});
        step();
        chk("len1_sv_second", 32'(c_sv), 32'd1);
        check_sum("len1_b", 2);
        c_pv = 1'b0;
        step();

        chk("sb_a_empty", 32'(q_a.size()), 32'd0);
        chk("sb_c_empty", 32'(q_c.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
# prod_accum

Block-accumulating stage placed directly downstream of the `shift_add` multiplier. It accepts unsigned products over a valid/ready handshake and sums exactly `LEN` of them into a wider accumulator. It then presents the block sum on a second valid/ready handshake and clears for the next block. Overflow handling is wrap or saturate, selectable at compile time.

## Interface
- `P_W`, default 16: product width (8×8 multiplier output).
- `ACC_W`, default 20: accumulator/sum width; must be ≥ `P_W`.
- `LEN`, default 4: products per block; legal range 1..255.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `prod_valid` in 1: `prod` carries a valid product.
- `prod` in `P_W`: unsigned product; zero-extended to `ACC_W`.
- `prod_ready` out 1: block can accept a product this cycle.
- `sum_valid` out 1: `sum` holds a completed block result.
- `sum_ready` in 1: consumer takes `sum` this cycle.
- `sum` out `ACC_W`: block result; stable while `sum_valid`=1.
- `cnt` out 8: products accepted in the current block.
- `ovf` out 1: overflow occurred in the current or presented block; sticky until the next block starts.

## Operation
- Two states: ACC and HOLD.
- **ACC**
  - `prod_ready`=1, `sum_valid`=0.
  - Accept occurs when `prod_valid && prod_ready`. On accept: `acc <= acc + zext(prod)` and `cnt <= cnt+1`.
  - Cycles with `prod_valid`=0 leave `acc` and `cnt` unchanged.
- **ACC → HOLD** on the accept that makes `cnt`==`LEN`.
  - That edge loads `sum` with the final value.
  - `sum_valid`=1 and `prod_ready`=0 from the next cycle.
- **HOLD**
  - `sum` and `ovf` are frozen.
  - `prod_valid` is ignored (no accept).
  - On `sum_valid && sum_ready`: `acc`←0, `cnt`←0, `ovf`←0, and return to ACC.
- **Arithmetic**
  - Unsigned, `ACC_W` bits.
  - Overflow means the carry out of bit `ACC_W-1`; it sets `ovf`.
  - Result on overflow is governed by the macro (see Configuration).
- **`LEN`=1:** every accepted product goes straight to HOLD.
- **Reset mid-operation:** `rst`=0 discards any partial block or pending sum at that edge.

## Timing
- Reset values after an edge with `rst`=0:
  - state ACC, `acc`=0, `cnt`=0, `sum`=0, `ovf`=0
  - `sum_valid`=0, `prod_ready`=1
- Latency: `sum_valid` rises 1 cycle after the `LEN`-th accept.
- Minimum block period: `LEN`+1 cycles (`LEN` accepts plus 1 HOLD cycle with `sum_ready`=1).
- The first product of the next block can be accepted no earlier than the cycle after the `sum` handshake.
- `prod_ready` is a registered function of state; it does not depend combinationally on `prod_valid` or `sum_ready`.
- `sum`, `sum_valid`, `cnt` and `ovf` are all registered outputs.

## Configuration
- Macro `PROD_ACCUM_SAT_EN`.
- **Defined:** on overflow, `acc` clamps to 2^`ACC_W`−1 and stays clamped for the rest of the block; `ovf`=1.
- **Undefined:** the sum wraps modulo 2^`ACC_W`; `ovf`=1 still flags the wrap.

## Structure
- Shared package `prod_accum_pkg` holds:
  - state enum (`ST_ACC`, `ST_HOLD`)
  - default width constants `P_W`/`ACC_W`
  - the `LEN` limit of 255
- One sub-module, `acc_add_sat`: combinational `ACC_W` adder with overflow output and macro-selected wrap or saturate.
- The FSM, counter and handshake registers live in the top level.

## Test plan
- Default params; four beats of `prod`=64 (8'd8×8'd8) back-to-back → `sum`=256, `sum_valid`=1 exactly 1 cycle after the 4th accept, `ovf`=0.
- Same four beats with `prod_valid` gapped (1-cycle bubbles) → `sum`=256, `cnt` steps 1,2,3,4 only on accepts.
- `sum_ready`=0 for 3 HOLD cycles while `prod_valid`=1 with `prod`=5 → `sum` held at 256, `prod_ready`=0, no accept; after `sum_ready`=1, `cnt`=0 and the next block starts cleanly.
- `ACC_W`=20, `LEN`=32, `prod`=16'hFFFF ×32:
  - wrap build → `sum`=20'hFFFE0, `ovf`=1
  - `PROD_ACCUM_SAT_EN` build → `sum`=20'hFFFFF, `ovf`=1
- Two accepts of 64, then `rst`=0 for 1 cycle → `cnt`=0, `sum_valid`=0, `prod_ready`=1; four accepts of `prod`=1 → `sum`=4.
- `LEN`=1 with `sum_ready` tied to 1 and `prod`=3,7 → `sum`=3 then 7, one result every 2 cycles.
